// File: rtl/ascon_serial_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ascon_serial_ctrl
// Brief    : Loads one parallel request into the bit-serial ASCON core, starts
//            it, and collects the serial data and tag into parallel results.
//            Optional tag comparison is enabled by defining ASCON_TAG_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ascon_serial_ctrl #(
    parameter int KEY_W           = 128,
    parameter int NONCE_W         = 128,
    parameter int AD_W            = 40,
    parameter int DATA_W          = 104,
    parameter int CORE_RST_CYCLES = 2,
    parameter int START_CYCLES    = 3,
    parameter int READ_DELAY      = 2,
    parameter int TIMEOUT         = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic               decrypt_i,
    input  logic [KEY_W-1:0]   key_i,
    input  logic [NONCE_W-1:0] nonce_i,
    input  logic [AD_W-1:0]    ad_i,
    input  logic [DATA_W-1:0]  data_i,
`ifdef ASCON_TAG_CHECK_EN
    input  logic [127:0]       exp_tag_i,
    output logic               tag_ok_o,
`endif
    output logic               core_rst_o,
    output logic               keyxSI,
    output logic               noncexSI,
    output logic               associated_dataxSI,
    output logic               output_dataxSI,
    output logic               ascon_startxSI,
    output logic               decrypt,
    input  logic               output_dataxSO,
    input  logic               tagxSO,
    input  logic               ascon_readyxSO,
    output logic               res_valid_o,
    output logic [DATA_W-1:0]  res_data_o,
    output logic [127:0]       res_tag_o,
    output logic               res_err_o,
    output logic               busy_o
);

    localparam int c_tag_w     = 128;
    localparam int c_max_kn    = (KEY_W > NONCE_W) ? KEY_W : NONCE_W;
    localparam int c_max_ad    = (AD_W > DATA_W) ? AD_W : DATA_W;
    localparam int c_shift_len = (c_max_kn > c_max_ad) ? c_max_kn : c_max_ad;
    localparam int c_cnt_max   = (c_shift_len > TIMEOUT) ? c_shift_len : TIMEOUT;
    localparam int c_cnt_w     = $clog2(c_cnt_max) + 1;

    localparam logic [c_cnt_w-1:0] c_crst_last    = c_cnt_w'(CORE_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_shift_last   = c_cnt_w'(c_shift_len - 1);
    localparam logic [c_cnt_w-1:0] c_start_last   = c_cnt_w'(START_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_delay_last   = c_cnt_w'(READ_DELAY - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_data_cnt     = c_cnt_w'(DATA_W);
    localparam logic [c_cnt_w-1:0] c_tag_cnt      = c_cnt_w'(c_tag_w);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_DELAY = 3'd5,
        S_READ  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [KEY_W-1:0]   r_key;
    logic [NONCE_W-1:0] r_nonce;
    logic [AD_W-1:0]    r_ad;
    logic [DATA_W-1:0]  r_data;

    logic w_accept;
    logic w_read_last;
    logic w_shift_en;

    assign w_accept    = req_valid_i & req_ready_o;
    assign w_read_last = (r_state == S_READ) && (r_cnt == c_shift_last);
    // The frame shifts out MSB first; the zero fill makes short fields read 0
    // once exhausted.
    assign w_shift_en  = ((r_state == S_CRST) && (r_cnt == c_crst_last)) ||
                         ((r_state == S_LOAD) && (r_cnt != c_shift_last));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state            <= S_IDLE;
            r_cnt              <= '0;
            r_key              <= '0;
            r_nonce            <= '0;
            r_ad               <= '0;
            r_data             <= '0;
            req_ready_o        <= 1'b0;
            busy_o             <= 1'b0;
            core_rst_o         <= 1'b1;
            keyxSI             <= 1'b0;
            noncexSI           <= 1'b0;
            associated_dataxSI <= 1'b0;
            output_dataxSI     <= 1'b0;
            ascon_startxSI     <= 1'b0;
            decrypt            <= 1'b0;
            res_valid_o        <= 1'b0;
            res_data_o         <= '0;
            res_tag_o          <= '0;
            res_err_o          <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    core_rst_o  <= 1'b0;
                    req_ready_o <= 1'b1;
                    if (w_accept) begin
                        r_key       <= key_i;
                        r_nonce     <= nonce_i;
                        r_ad        <= ad_i;
                        r_data      <= data_i;
                        decrypt     <= decrypt_i;
                        res_data_o  <= '0;
                        res_tag_o   <= '0;
                        res_err_o   <= 1'b0;
                        core_rst_o  <= 1'b1;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_CRST;
                    end
                end
                S_CRST: begin
                    if (r_cnt == c_crst_last) begin
                        core_rst_o <= 1'b0;
                        r_cnt      <= '0;
                        r_state    <= S_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_LOAD: begin
                    if (r_cnt == c_shift_last) begin
                        keyxSI             <= 1'b0;
                        noncexSI           <= 1'b0;
                        associated_dataxSI <= 1'b0;
                        output_dataxSI     <= 1'b0;
                        ascon_startxSI     <= 1'b1;
                        r_cnt              <= '0;
                        r_state            <= S_START;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_START: begin
                    if (r_cnt == c_start_last) begin
                        ascon_startxSI <= 1'b0;
                        r_cnt          <= '0;
                        r_state        <= S_WAIT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (ascon_readyxSO) begin
                        r_cnt   <= '0;
                        r_state <= S_DELAY;
                    end else if (r_cnt == c_timeout_last) begin
                        res_err_o   <= 1'b1;
                        res_valid_o <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DELAY: begin
                    if (r_cnt == c_delay_last) begin
                        r_cnt   <= '0;
                        r_state <= S_READ;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_READ: begin
                    // Shifting in at the MSB leaves the first bit at index 0.
                    if (r_cnt < c_data_cnt) begin
                        res_data_o <= {output_dataxSO, res_data_o[DATA_W-1:1]};
                    end
                    if (r_cnt < c_tag_cnt) begin
                        res_tag_o <= {tagxSO, res_tag_o[c_tag_w-1:1]};
                    end
                    if (w_read_last) begin
                        res_valid_o <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    res_valid_o <= 1'b0;
                    req_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            if (w_shift_en) begin
                keyxSI             <= r_key[KEY_W-1];
                noncexSI           <= r_nonce[NONCE_W-1];
                associated_dataxSI <= r_ad[AD_W-1];
                output_dataxSI     <= r_data[DATA_W-1];
                r_key              <= {r_key[KEY_W-2:0], 1'b0};
                r_nonce            <= {r_nonce[NONCE_W-2:0], 1'b0};
                r_ad               <= {r_ad[AD_W-2:0], 1'b0};
                r_data             <= {r_data[DATA_W-2:0], 1'b0};
            end
        end
    end

`ifdef ASCON_TAG_CHECK_EN
    logic [c_tag_w-1:0] r_exp_tag;
    logic [c_tag_w-1:0] w_tag_final;

    // Compare against the tag as it will look once the last READ bit lands,
    // so tag_ok_o is valid in the same cycle as res_valid_o.
    assign w_tag_final = (r_cnt < c_tag_cnt) ? {tagxSO, res_tag_o[c_tag_w-1:1]} : res_tag_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exp_tag <= '0;
            tag_ok_o  <= 1'b0;
        end else if (w_accept) begin
            r_exp_tag <= exp_tag_i;
            tag_ok_o  <= 1'b0;
        end else if (w_read_last) begin
            tag_ok_o  <= decrypt & (w_tag_final == r_exp_tag);
        end
    end
`else
    // Default build: no expected-tag register and no comparator.
`endif

endmodule
`default_nettype wire

// File: doc/ascon_serial_ctrl.md
Name: ascon_serial_ctrl

Overview:
Upstream sequencer for the bit-serial ASCON core. It accepts one full-width request: mode, key, nonce, associated data and plaintext or ciphertext. It then resets the core and shifts all fields into the core serially, pulses start, and waits for ready. Finally it deserializes the returned data and tag into parallel result registers for the management SoC and logic-analyzer side of the user project.

Parameters:
KEY_W, 128, key width in bits
NONCE_W, 128, nonce width in bits (fixed 128)
AD_W, 40, associated-data width in bits
DATA_W, 104, plaintext/ciphertext width in bits
SHIFT_LEN, max(KEY_W,NONCE_W,AD_W,DATA_W), serial frame length in cycles; derived, not overridden
CORE_RST_CYCLES, 2, cycles core_rst_o is held high before loading
START_CYCLES, 3, cycles ascon_startxSI is held high
READ_DELAY, 2, cycles between ready sampled high and first output bit captured
TIMEOUT, 1024, maximum WAIT cycles before error

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_valid_i  in  1  request valid
req_ready_o  out  1  high only in IDLE
decrypt_i  in  1  0 = encrypt, 1 = decrypt
key_i  in  KEY_W  key
nonce_i  in  NONCE_W  nonce
ad_i  in  AD_W  associated data
data_i  in  DATA_W  plaintext or ciphertext
core_rst_o  out  1  core reset
keyxSI, noncexSI, associated_dataxSI, output_dataxSI  out  1 each  serial fields to core
ascon_startxSI  out  1  core start
decrypt  out  1  core mode, registered from the request
output_dataxSO, tagxSO, ascon_readyxSO  in  1 each  from core
res_valid_o  out  1  one-cycle result strobe
res_data_o  out  DATA_W  captured data
res_tag_o  out  128  captured tag
res_err_o  out  1  timeout flag
busy_o  out  1  high when not in IDLE

Behaviour:
- Reset values (asynchronous): state IDLE, core_rst_o = 1, all other outputs 0, result registers 0. On the first clk after rst deasserts, core_rst_o = 0.
- Reset mid-operation: abort immediately; no res_valid_o is produced.
- States and transitions:
  - IDLE: req_ready_o = 1. On accept (req_valid_i & req_ready_o), latch all inputs, drive decrypt, clear res_*, go to CRST.
  - CRST: core_rst_o = 1 for CORE_RST_CYCLES, then go to LOAD.
  - LOAD: SHIFT_LEN cycles, counter n = 0..SHIFT_LEN-1. Drive keyxSI = key[KEY_W-1-n], noncexSI = nonce[127-n], associated_dataxSI = ad[AD_W-1-n], output_dataxSI = data[DATA_W-1-n] (MSB first). Once a field is exhausted (n >= its width), drive that line 0.
  - START: ascon_startxSI = 1 for START_CYCLES; serial data lines are 0.
  - WAIT: exit to DELAY on ascon_readyxSO sampled 1. After TIMEOUT cycles, set res_err_o = 1 and go to DONE.
  - DELAY: READ_DELAY cycles, then go to READ.
  - READ: SHIFT_LEN cycles, counter i. Capture res_data_o[i] = output_dataxSO when i < DATA_W and res_tag_o[i] = tagxSO when i < 128; bits at higher indices are discarded. First captured bit lands at index 0.
  - DONE: res_valid_o = 1 for exactly one cycle, then go to IDLE.
- All core-facing outputs are registered; no combinational path from the core inputs to any output.
- res_data_o, res_tag_o and res_err_o hold their values until the next accept.
- req_valid_i is ignored outside IDLE.
- Counters are sized to $clog2 of the largest of SHIFT_LEN and TIMEOUT, plus 1.
- Defaults latency, accept to res_valid_o: 2 + 128 + 3 + W + 2 + 128 + 1 cycles, where W is the number of WAIT cycles.

Optional Feature:
ASCON_TAG_CHECK_EN
- Defined: adds input exp_tag_i[127:0] (latched on accept) and output tag_ok_o. In DONE, tag_ok_o = decrypt & ~res_err_o & (res_tag_o == exp_tag); it holds until the next accept and resets to 0.
- Undefined: neither port exists and no comparator is synthesized.

Test Plan:
- Encrypt, data = 0x6173636f6e2d756e6963617373, key = 0x80000000_00000000_00000000_00000001, ad = 0xA500000001 -> keyxSI high only on LOAD cycles 0 and 127; associated_dataxSI high on cycles 0, 2, 5, 7 and 39, and 0 from cycle 40 on; output_dataxSI reproduces the 104 data bits MSB first, then 0.
- Bench core model raises ready 50 cycles after start falls and streams a known pattern -> res_valid_o exactly 2 + 128 + 3 + 50 + 2 + 128 + 1 cycles after accept; res_data_o = 0x18490112f8d5867a830748390b, with matching tag; res_err_o = 0.
- Decrypt with data = 0x18490112f8d5867a830748390b -> decrypt = 1 throughout the transaction; model returns 0x6173636f6e2d756e6963617373; core_rst_o high for 2 cycles after accept.
- Ready held low -> res_err_o = 1 and res_valid_o after 1024 WAIT cycles; next request completes normally.
- rst pulsed during LOAD at n = 60 -> outputs return to reset values at once, no res_valid_o, req_ready_o = 1 one cycle after release; req_valid_i asserted during a busy transaction is ignored.
- With ASCON_TAG_CHECK_EN: exp_tag equal to returned tag -> tag_ok_o = 1; one bit flipped -> tag_ok_o = 0.
